// File: rtl/interp_pkg.sv
// Shared FSM state encoding and the overflow fit (wrap or clamp) used when writing lanes.
package interp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Wide enough for a 2*DATA_W+2 accumulator with DATA_W up to 64.
  localparam int ACC_MAX_W = 130;
  typedef logic signed [ACC_MAX_W-1:0] acc_t;

  // Flags values outside the signed w-bit range; clamps them when sat_en, else passes through for wrap.
  function automatic acc_t fit_word(input acc_t val, input int w, input logic sat_en, output logic ovf);
    acc_t hi;
    acc_t lo;
    hi  = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo  = ~hi;
    ovf = (val > hi) || (val < lo);
    if (ovf && sat_en)
      return val[ACC_MAX_W-1] ? lo : hi;
    return val;
  endfunction

endpackage

// File: rtl/attr_interpolator_if.sv
// Bundle-in / result-out handshake bus of the attribute interpolator.
interface attr_interpolator_if #(
  parameter int NUM_ATTR = 8,
  parameter int DATA_W   = 32
);
  localparam int CNT_W = $clog2(NUM_ATTR + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] bary [3];
  logic signed [DATA_W-1:0] vtx_attr [3][NUM_ATTR];
  logic [CNT_W-1:0]         attr_count;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_attr [NUM_ATTR];
  logic [CNT_W-1:0]         out_count;
  logic                     sat_flag;

  modport master (
    output in_valid, bary, vtx_attr, attr_count, out_ready,
    input  in_ready, out_valid, out_attr, out_count, sat_flag
  );

  modport slave (
    input  in_valid, bary, vtx_attr, attr_count, out_ready,
    output in_ready, out_valid, out_attr, out_count, sat_flag
  );
endinterface

// File: rtl/interp_mac.sv
// Signed multiply-accumulate; sh is (acc + a*b) >>> FRAC_W, acc cleared on clr or after a last product.
// Single cycle per product, no backpressure: the owner decides when en is asserted.
module interp_mac #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       last,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W+1:0] sh
);
  localparam int ACC_W = 2 * DATA_W + 2;

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_nxt;
  logic signed [2*DATA_W-1:0] prod;

  assign prod    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign acc_nxt = acc_q + ACC_W'(prod);
  assign sh      = acc_nxt >>> FRAC_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else if (clr)
      acc_q <= '0;
    else if (en)
      acc_q <= last ? '0 : acc_nxt;
  end
endmodule

// File: rtl/attr_interpolator.sv
// Barycentric attribute interpolation, one product per cycle; ATTR_INTERP_SAT_EN clamps overflow (default wraps).
// Result 3*count+1 cycles after accept; in_ready only when idle, result held until out_ready.
module attr_interpolator
  import interp_pkg::*;
#(
  parameter int NUM_ATTR = 8,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16
) (
  input logic                clk,
  input logic                rst_n,
  attr_interpolator_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_ATTR + 1);
  localparam int IDX_W = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;

`ifdef ATTR_INTERP_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] bary_q [3];
  logic signed [DATA_W-1:0] vtx_q  [3][NUM_ATTR];
  logic signed [DATA_W-1:0] lane_q [NUM_ATTR];
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         eff_cnt;
  logic [1:0]               v_q;
  logic [IDX_W-1:0]         a_q;
  logic                     sat_q;

  logic                      in_rdy, out_vld, accept, mac_en, lane_done, last_lane;
  logic signed [2*DATA_W+1:0] mac_sh;
  acc_t                      sh_ext;
  logic [DATA_W-1:0]         fit_dat;
  logic                      fit_ovf;

  assign eff_cnt   = (bus.attr_count > CNT_W'(NUM_ATTR)) ? CNT_W'(NUM_ATTR) : bus.attr_count;
  assign accept    = in_rdy && bus.in_valid;
  assign lane_done = (v_q == 2'd2);
  assign last_lane = ((CNT_W'(a_q) + CNT_W'(1)) == cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid)
          state_d = (eff_cnt == '0) ? OUT : MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (lane_done && last_lane)
          state_d = OUT;
      end
      OUT: begin
        out_vld = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  interp_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (mac_en),
    .last  (lane_done),
    .a     (bary_q[v_q]),
    .b     (vtx_q[v_q][a_q]),
    .sh    (mac_sh)
  );

  assign sh_ext = ACC_MAX_W'(mac_sh);

  always_comb begin
    fit_ovf = 1'b0;
    fit_dat = DATA_W'(fit_word(sh_ext, DATA_W, SAT_EN, fit_ovf));
  end

  // Lanes are zeroed on accept so lanes beyond the count read back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < 3; v++) begin
        bary_q[v] <= '0;
        for (int a = 0; a < NUM_ATTR; a++)
          vtx_q[v][a] <= '0;
      end
      for (int a = 0; a < NUM_ATTR; a++)
        lane_q[a] <= '0;
      cnt_q <= '0;
      v_q   <= '0;
      a_q   <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      for (int v = 0; v < 3; v++) begin
        bary_q[v] <= bus.bary[v];
        for (int a = 0; a < NUM_ATTR; a++)
          vtx_q[v][a] <= bus.vtx_attr[v][a];
      end
      for (int a = 0; a < NUM_ATTR; a++)
        lane_q[a] <= '0;
      cnt_q <= eff_cnt;
      v_q   <= '0;
      a_q   <= '0;
      sat_q <= 1'b0;
    end else if (mac_en) begin
      if (lane_done) begin
        lane_q[a_q] <= fit_dat;
        sat_q       <= sat_q | fit_ovf;
        v_q         <= '0;
        a_q         <= a_q + IDX_W'(1);
      end else begin
        v_q <= v_q + 2'd1;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_count = cnt_q;
  assign bus.sat_flag  = sat_q;

  for (genvar i = 0; i < NUM_ATTR; i++) begin : g_out
    assign bus.out_attr[i] = lane_q[i];
  end
endmodule

// File: tb/tb_attr_interpolator.sv
// Directed bench for attr_interpolator with hand-computed expected results.
module tb_attr_interpolator;
  localparam int NA = 8;
  localparam int DW = 32;
  localparam int FW = 16;

`ifdef ATTR_INTERP_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFD;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attr_interpolator_if #(.NUM_ATTR(NA), .DATA_W(DW)) bus ();

  attr_interpolator #(.NUM_ATTR(NA), .DATA_W(DW), .FRAC_W(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_bary(input logic [31:0] u, input logic [31:0] v, input logic [31:0] w);
    bus.bary[0] = u;
    bus.bary[1] = v;
    bus.bary[2] = w;
  endtask

  task automatic fill_attrs(input logic [31:0] val);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < NA; a++)
        bus.vtx_attr[v][a] = val;
  endtask

  task automatic load_basic();
    set_bary(32'h4000, 32'h4000, 32'h8000);
    fill_attrs(32'h10000);
    bus.vtx_attr[0][0] = 32'h40000;
    bus.vtx_attr[1][0] = 32'h80000;
    bus.vtx_attr[2][0] = 32'hC0000;
  endtask

  // Offers one bundle and returns accept-to-out_valid latency in cycles (accept cycle excluded).
  task automatic send(input logic [3:0] cnt, output int l);
    @(negedge clk);
    bus.attr_count = cnt;
    bus.in_valid   = 1'b1;
    check("accept_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < 200) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_in_ready", bus.in_ready, 1);
    check("drain_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.attr_count = '0;
    set_bary(0, 0, 0);
    fill_attrs(0);
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_sat", bus.sat_flag, 0);
    check("rst_lane0", bus.out_attr[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0.25*4 + 0.25*8 + 0.5*12 = 9.0
    load_basic();
    send(4'd1, lat);
    check("basic_latency", lat, 4);
    check("basic_lane0", bus.out_attr[0], 32'h90000);
    check("basic_sat", bus.sat_flag, 0);
    check("basic_count", bus.out_count, 1);
    for (int a = 1; a < NA; a++)
      check($sformatf("basic_lane%0d_zero", a), bus.out_attr[a], 0);
    drain();

    send(4'd0, lat);
    check("zero_latency", lat, 1);
    check("zero_count", bus.out_count, 0);
    for (int a = 0; a < NA; a++)
      check($sformatf("zero_lane%0d", a), bus.out_attr[a], 0);
    drain();

    // 0.5*(a+1) + 0.25*4 - 0.25*(a+1) = 1 + 0.25*(a+1)
    set_bary(32'h8000, 32'h4000, 32'h4000);
    for (int a = 0; a < NA; a++) begin
      bus.vtx_attr[0][a] = (a + 1) << 16;
      bus.vtx_attr[1][a] = 32'h40000;
      bus.vtx_attr[2][a] = -((a + 1) << 16);
    end
    send(4'd11, lat);
    check("full_latency", lat, 3 * NA + 1);
    check("full_count", bus.out_count, NA);
    check("full_sat", bus.sat_flag, 0);
    for (int a = 0; a < NA; a++)
      check($sformatf("full_lane%0d", a), bus.out_attr[a], 32'h10000 + (a + 1) * 32'h4000);
    drain();

    set_bary(32'h10000, 32'h10000, 32'h10000);
    fill_attrs(32'h7FFF_FFFF);
    send(4'd1, lat);
    check("sat_latency", lat, 4);
    check("sat_flag", bus.sat_flag, 1);
    check("sat_lane0", bus.out_attr[0], SAT_EXP);
    drain();

    // Tiny weight times -1 floors to -1; sat_flag must clear on the new bundle.
    set_bary(32'h1, 32'h0, 32'h0);
    fill_attrs(32'h7FFF_FFFF);
    bus.vtx_attr[0][0] = 32'hFFFF_FFFF;
    bus.vtx_attr[0][1] = 32'h30000;
    send(4'd2, lat);
    check("floor_latency", lat, 7);
    check("floor_lane0", bus.out_attr[0], 32'hFFFF_FFFF);
    check("floor_lane1", bus.out_attr[1], 32'h3);
    check("floor_sat", bus.sat_flag, 0);

    load_basic();
    bus.attr_count = 4'd1;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_lane0", bus.out_attr[0], 32'hFFFF_FFFF);
      check("hold_count", bus.out_count, 2);
    end
    bus.in_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("ignored_out_valid", bus.out_valid, 0);
    check("ignored_in_ready", bus.in_ready, 1);

    load_basic();
    @(negedge clk);
    bus.attr_count = 4'd8;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_count", bus.out_count, 0);
    check("midrst_sat", bus.sat_flag, 0);
    check("midrst_lane0", bus.out_attr[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd1, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_lane0", bus.out_attr[0], 32'h90000);
    check("post_rst_lane1", bus.out_attr[1], 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/attr_interpolator.md
ATTR_INTERPOLATOR -- requirements
Module: attr_interpolator

Interface
REQ-001 SHALL have parameter NUM_ATTR, default 8, number of attribute lanes (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, signed fixed-point word width.
REQ-003 SHALL have parameter FRAC_W, default 16, fractional bits of all inputs and outputs (FRAC_W < DATA_W).
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  in  1  input bundle valid.
REQ-007 SHALL have port in_ready  out  1  block can accept a bundle.
REQ-008 SHALL have port bary[3]  in  DATA_W  signed barycentric weights u,v,w.
REQ-009 SHALL have port vtx_attr[3][NUM_ATTR]  in  DATA_W  signed per-vertex attributes.
REQ-010 SHALL have port attr_count  in  $clog2(NUM_ATTR+1)  number of lanes to compute.
REQ-011 SHALL have port out_valid  out  1  result bundle valid.
REQ-012 SHALL have port out_ready  in  1  consumer accepts result.
REQ-013 SHALL have port out_attr[NUM_ATTR]  out  DATA_W  interpolated attributes.
REQ-014 SHALL have port out_count  out  $clog2(NUM_ATTR+1)  effective lane count of the result.
REQ-015 SHALL have port sat_flag  out  1  at least one lane overflowed DATA_W in this result.

Function
REQ-016 SHALL implement states IDLE, MAC, OUT; in_ready=1 only in IDLE, out_valid=1 only in OUT.
REQ-017 SHALL capture bary, vtx_attr and effective count on in_valid&&in_ready; IDLE->MAC, or IDLE->OUT if effective count is 0.
REQ-018 SHALL set effective count = min(attr_count, NUM_ATTR).
REQ-019 SHALL in MAC perform exactly one signed product bary[v]*vtx_attr[v][a] per cycle, v innermost 0..2, a 0..count-1, accumulating at 2*DATA_W+2 bits.
REQ-020 SHALL after v=2 write lane a = accumulator arithmetically shifted right by FRAC_W (truncation toward minus infinity), then clear the accumulator.
REQ-021 SHALL leave MAC for OUT on the cycle after the last product; latency from accept to out_valid = 3*count+1 cycles (1 cycle when count=0).
REQ-022 SHALL drive lanes >= count to zero in out_attr.
REQ-023 SHALL hold out_valid, out_attr, out_count, sat_flag stable in OUT until out_ready; on out_valid&&out_ready go to IDLE.
REQ-024 SHALL ignore in_valid outside IDLE and ignore out_ready outside OUT.
REQ-025 SHALL without saturation wrap the shifted result to DATA_W bits (two's complement) and still set sat_flag when it does not fit.

Reset
REQ-026 SHALL on rst_n low immediately enter IDLE: in_ready=1, out_valid=0, out_attr all 0, out_count=0, sat_flag=0, accumulator and counters 0.
REQ-027 SHALL abandon any in-flight bundle when reset asserts mid-MAC or mid-OUT; no partial result is ever presented.

Configuration
REQ-028 SHALL, with macro ATTR_INTERP_SAT_EN defined, clamp each overflowing lane to the largest positive or most negative DATA_W value, sat_flag as in REQ-025.
REQ-029 SHALL, without ATTR_INTERP_SAT_EN, use wrap behaviour of REQ-025; all other behaviour identical.

Structure
REQ-030 SHALL place the state enum and the saturate/wrap function in shared package interp_pkg.
REQ-031 SHALL use one sub-module interp_mac (signed multiply, accumulate, clear, shift-out) instantiated once; the FSM and lane registers stay in attr_interpolator.

Verification
REQ-032 SHALL cover: bary=(0x4000,0x4000,0x8000), lane0 attrs (0x40000,0x80000,0xC0000), count=1 -> out_attr[0]=0x90000, out_valid 4 cycles after accept, sat_flag=0.
REQ-033 SHALL cover: count=0 -> out_valid 1 cycle after accept, all lanes 0, out_count=0.
REQ-034 SHALL cover: count=NUM_ATTR+3 (if representable) or NUM_ATTR -> out_count=NUM_ATTR, latency 3*NUM_ATTR+1.
REQ-035 SHALL cover: bary=(0x10000,0x10000,0x10000), attrs all 0x7FFFFFFF -> sat_flag=1; lane=0x7FFFFFFF with ATTR_INTERP_SAT_EN, 0x7FFFFFFD without.
REQ-036 SHALL cover: out_ready held 0 for 10 cycles -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037 SHALL cover: rst_n pulsed low during MAC -> outputs at reset values same cycle, next accepted bundle produces correct result.
